// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, occupancy count and threshold flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise those ports read 0.
module sync_fifo_param #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Handshake: wr_en/rd_en are requests; a write is taken when wr_en && !full and a
  // read when rd_en && !empty, both judged on pre-edge flags. clr overrides both.
  // A taken read presents its word on dout with dout_valid high for exactly the next cycle.
  assign wr_acc = wr_en && !full && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
      dout_valid <= rd_acc;
      // count tracks wr_ptr - rd_ptr incrementally so the flags decode from a register
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
